prio_arbiter: RTL and testbench

Parametrised, registered successor to the team's 4-input priority encoder. Selects one of `N` request lines in fixed-priority (highest index wins) or round-robin mode and presents the winner as index plus one-hot on a valid/ready output port. It sits between request-generating clients and a single shared resource, holding each grant stable until the consumer accepts it.

---
 rtl/prio_pkg.sv | 16 +
 rtl/prio_pick.sv | 47 ++++
 rtl/prio_arbiter.sv | 103 ++++++++++
 tb/tb_prio_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/prio_pkg.sv
// Shared types and helpers for the parametrised priority / round-robin arbiter.
package prio_pkg;

  // Arbitration policy selected per decision.
  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // True when more than one bit of the (zero-extended) request vector is set.
  // Clearing the lowest set bit leaves something only if a second bit exists.
  function automatic logic popcount_gt1(input logic [63:0] v);
    return ((v & (v - 64'd1)) != 64'd0);
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational picker: first set request found searching downward from
// start, wrapping from index 0 back to N-1.
module prio_pick
  import prio_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [N-1:0] low_s;
  logic         low_found_s;
  logic [W-1:0] low_idx_s;
  logic [W-1:0] any_idx_s;

  // Requests at or below start take precedence; otherwise the wrap-around
  // winner is simply the highest set request overall.
  always_comb begin
    low_s       = {N{1'b0}};
    low_found_s = 1'b0;
    low_idx_s   = {W{1'b0}};
    any_idx_s   = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      low_s[i] = req[i] && (W'(i) <= start);
    end
    for (int i = 0; i < N; i++) begin
      if (low_s[i]) begin
        low_found_s = 1'b1;
        low_idx_s   = W'(i);
      end else begin
        low_found_s = low_found_s;
      end
      if (req[i]) begin
        any_idx_s = W'(i);
      end else begin
        any_idx_s = any_idx_s;
      end
    end
    found = |req;
    idx   = low_found_s ? low_idx_s : any_idx_s;
  end

endmodule

// File: rtl/prio_arbiter.sv
// Registered N-input arbiter (fixed priority or round-robin) presenting its
// grant on a valid/ready port and holding it until accepted.
module prio_arbiter
  import prio_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         out_multi
);

  localparam logic [W-1:0] TOP_IDX = W'(N - 1);

  logic         valid_q,  valid_d;
  logic [W-1:0] idx_q,    idx_d;
  logic [N-1:0] onehot_q, onehot_d;
  logic         multi_q,  multi_d;
  logic [W-1:0] ptr_q,    ptr_d;

  logic         slot_free_s;
  logic         hs_s;
  logic [W-1:0] start_s;
  logic         pick_found_s;
  logic [W-1:0] pick_idx_s;

  // Handshake and pointer-next; the updated pointer feeds this cycle's
  // round-robin search so a just-accepted client is not served again first.
  always_comb begin
    slot_free_s = !valid_q || out_ready;
    hs_s        = valid_q && out_ready;
    if (hs_s) begin
      ptr_d = (idx_q == {W{1'b0}}) ? TOP_IDX : (idx_q - W'(1));
    end else begin
      ptr_d = ptr_q;
    end
    if (arb_mode_e'(mode) == ARB_RR) begin
      start_s = ptr_d;
    end else begin
      start_s = TOP_IDX;
    end
  end

  prio_pick #(.N(N), .W(W)) u_pick (
    .req   (req),
    .start (start_s),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Next grant: decide only when the slot is free, otherwise hold.
  always_comb begin
    valid_d  = valid_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    multi_d  = multi_q;
    if (slot_free_s) begin
      if (pick_found_s) begin
        valid_d  = 1'b1;
        idx_d    = pick_idx_s;
        onehot_d = {{(N-1){1'b0}}, 1'b1} << pick_idx_s;
        multi_d  = popcount_gt1(64'(req));
      end else begin
        valid_d  = 1'b0;
        idx_d    = {W{1'b0}};
        onehot_d = {N{1'b0}};
        multi_d  = 1'b0;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Grant and pointer registers; reset discards any outstanding grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      idx_q    <= {W{1'b0}};
      onehot_q <= {N{1'b0}};
      multi_q  <= 1'b0;
      ptr_q    <= TOP_IDX;
    end else begin
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      multi_q  <= multi_d;
      ptr_q    <= ptr_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_idx    = idx_q;
  assign out_onehot = onehot_q;
  assign out_multi  = multi_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed, table-driven bench for prio_arbiter with N=8.
module tb_prio_arbiter;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         mode;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic         out_multi;

  int total;
  int bad;

  typedef struct {
    logic [7:0] req;
    logic       mode;
    logic       rdy;
    logic       v;
    logic [2:0] idx;
    logic [7:0] oh;
    logic       m;
  } vec_t;

  vec_t tbl[25];

  prio_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mode       (mode),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_idx    (out_idx),
    .out_onehot (out_onehot),
    .out_multi  (out_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [2:0] idx,
                           input logic [7:0] oh, input logic m);
    check({tag, ".valid"},  32'(out_valid),  32'(v));
    check({tag, ".idx"},    32'(out_idx),    32'(idx));
    check({tag, ".onehot"}, 32'(out_onehot), 32'(oh));
    check({tag, ".multi"},  32'(out_multi),  32'(m));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //          req    mode rdy  v    idx   oh     m
    tbl[0]  = '{8'h0F, 1'b0, 1'b1, 1'b1, 3'd3, 8'h08, 1'b1};
    tbl[1]  = '{8'hA0, 1'b0, 1'b1, 1'b1, 3'd7, 8'h80, 1'b1};
    tbl[2]  = '{8'hA0, 1'b0, 1'b1, 1'b1, 3'd7, 8'h80, 1'b1};
    tbl[3]  = '{8'hA0, 1'b0, 1'b1, 1'b1, 3'd7, 8'h80, 1'b1};
    tbl[4]  = '{8'hA0, 1'b0, 1'b1, 1'b1, 3'd7, 8'h80, 1'b1};
    tbl[5]  = '{8'h01, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 1'b0};
    tbl[6]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    // round-robin sweep with all requests, pointer back at 7
    tbl[7]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80, 1'b1};
    tbl[8]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 3'd6, 8'h40, 1'b1};
    tbl[9]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 3'd5, 8'h20, 1'b1};
    tbl[10] = '{8'hFF, 1'b1, 1'b1, 1'b1, 3'd4, 8'h10, 1'b1};
    tbl[11] = '{8'hFF, 1'b1, 1'b1, 1'b1, 3'd3, 8'h08, 1'b1};
    tbl[12] = '{8'hFF, 1'b1, 1'b1, 1'b1, 3'd2, 8'h04, 1'b1};
    tbl[13] = '{8'hFF, 1'b1, 1'b1, 1'b1, 3'd1, 8'h02, 1'b1};
    tbl[14] = '{8'hFF, 1'b1, 1'b1, 1'b1, 3'd0, 8'h01, 1'b1};
    tbl[15] = '{8'hFF, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80, 1'b1};
    // back-pressure: idx 5 held while req moves to 0x80
    tbl[16] = '{8'h20, 1'b0, 1'b1, 1'b1, 3'd5, 8'h20, 1'b0};
    tbl[17] = '{8'h80, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20, 1'b0};
    tbl[18] = '{8'h80, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20, 1'b0};
    tbl[19] = '{8'h80, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20, 1'b0};
    tbl[20] = '{8'h80, 1'b0, 1'b1, 1'b1, 3'd7, 8'h80, 1'b0};
    // mode switch: accept 6 in fixed, then RR from pointer 5
    tbl[21] = '{8'h40, 1'b0, 1'b1, 1'b1, 3'd6, 8'h40, 1'b0};
    tbl[22] = '{8'hC1, 1'b1, 1'b1, 1'b1, 3'd0, 8'h01, 1'b1};
    tbl[23] = '{8'hC1, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80, 1'b1};
    tbl[24] = '{8'hC1, 1'b1, 1'b1, 1'b1, 3'd6, 8'h40, 1'b1};

    // reset with all requests active
    rst_n     = 1'b0;
    req       = 8'hFF;
    mode      = 1'b1;
    out_ready = 1'b1;
    #3;
    check_all("reset_async", 1'b0, 3'd0, 8'h00, 1'b0);
    step();
    step();
    check_all("reset_hold", 1'b0, 3'd0, 8'h00, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      req       = tbl[i].req;
      mode      = tbl[i].mode;
      out_ready = tbl[i].rdy;
      step();
      check_all($sformatf("vec%0d", i), tbl[i].v, tbl[i].idx, tbl[i].oh, tbl[i].m);
    end

    // accept idx 3 once so the pointer sits at 2, then stall on idx 3
    req       = 8'h08;
    mode      = 1'b0;
    out_ready = 1'b1;
    step();
    check_all("pre_rst_a", 1'b1, 3'd3, 8'h08, 1'b0);
    step();
    check_all("pre_rst_b", 1'b1, 3'd3, 8'h08, 1'b0);
    out_ready = 1'b0;
    step();
    check_all("pre_rst_stall", 1'b1, 3'd3, 8'h08, 1'b0);

    // asynchronous reset pulse mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check_all("mid_rst", 1'b0, 3'd0, 8'h00, 1'b0);
    #1;
    rst_n = 1'b1;

    // outstanding grant must not come back
    req       = 8'h00;
    out_ready = 1'b1;
    step();
    check_all("post_rst_idle", 1'b0, 3'd0, 8'h00, 1'b0);

    // pointer restarted at 7: RR with 0x09 grants 3 then 0
    req  = 8'h09;
    mode = 1'b1;
    step();
    check_all("post_rst_rr0", 1'b1, 3'd3, 8'h08, 1'b1);
    step();
    check_all("post_rst_rr1", 1'b1, 3'd0, 8'h01, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
